dmem_banked_ctrl: RTL and testbench



---
 rtl/dmem_banked_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dmem_banked_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_banked_ctrl.sv
// dmem_banked_ctrl: byte-lane banked data memory for the CPU load/store path.
// Latency: a request accepted in cycle N pulses ready_o in cycle N+2+WAIT_CYCLES.
// Backpressure: one access in flight; req_i outside IDLE is dropped, never queued.
// Ports: clk_i, rst_i (synchronous, active-high); request req_i/we_i/mem_op_i/addr_i/wdata_i;
//        completion rdata_o/ready_o/fault_o; busy_o while an access is in flight.
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of splitting them.
module dmem_banked_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 14,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        mem_op_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ready_o,
  output logic              busy_o,
  output logic              fault_o
);

  localparam int NLANES = DATA_W / 8;
  localparam int OFF_W  = $clog2(NLANES);
  localparam logic [2:0] WLAST = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t                  state_q;
  logic                    we_q;
  logic [2:0]              op_q;
  logic [OFF_W-1:0]        off_q;
  logic [DEPTH_LOG2-1:0]   row_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [2:0]              wcnt_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    ready_q, busy_q, fault_q;

  logic [3:0]              size;
  logic                    legal, mis, access_ok, go_done, upd_rdata;
  logic [NLANES-1:0]       lane_sel;
  logic [NLANES-1:0][7:0]  wbyte;
  logic [DATA_W-1:0]       rd_w, gath, rdata_d;
  logic [OFF_W-1:0]        widx, ridx;
  logic                    sbit;
  int                      sidx;

  // Upper address bits alias the memory and are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^addr_i[31:OFF_W+DEPTH_LOG2];

  assign size  = 4'd1 << op_q[1:0];
  assign legal = (op_q != 3'd7) && !((DATA_W == 32) && ((op_q == 3'd3) || (op_q == 3'd6)));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = |({{(4-OFF_W){1'b0}}, off_q} & (size - 4'd1));
`else
  assign mis = 1'b0;
`endif

  assign access_ok = legal && !mis;
  // Stores leave rdata alone unless the access was rejected, which reports zero.
  assign upd_rdata = !we_q || !access_ok;
  assign go_done   = ((state_q == S_ACCESS) && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && (wcnt_q == WLAST));

  // Lane l carries access byte (l - off) mod NLANES; only the first size bytes are live.
  always_comb begin
    lane_sel = '0;
    wbyte    = '0;
    widx     = '0;
    for (int l = 0; l < NLANES; l++) begin
      widx        = OFF_W'(l) - off_q;
      lane_sel[l] = int'(widx) < int'(size);
      wbyte[l]    = wdata_q[int'(widx)*8 +: 8];
    end
  end

  for (genvar l = 0; l < NLANES; l++) begin : g_bank
    logic [7:0]            mem [2**DEPTH_LOG2];
    logic [7:0]            bank_rd_q;
    logic [DEPTH_LOG2-1:0] row_l;
    logic                  en;

    // Lanes below the offset belong to the next row of a straddling access.
    assign row_l = (OFF_W'(l) < off_q) ? row_q + 1'b1 : row_q;
    assign en    = (state_q == S_ACCESS) && access_ok && lane_sel[l];

    always_ff @(posedge clk_i) begin
      if (en) begin
        if (we_q) mem[row_l] <= wbyte[l];
        bank_rd_q <= mem[row_l];
      end
    end

    assign rd_w[l*8 +: 8] = bank_rd_q;
  end

  // Rotate lanes back to byte 0, then zero/sign extend above the access size.
  always_comb begin
    gath    = '0;
    rdata_d = '0;
    ridx    = '0;
    for (int k = 0; k < NLANES; k++) begin
      ridx           = OFF_W'(k) + off_q;
      gath[k*8 +: 8] = rd_w[int'(ridx)*8 +: 8];
    end
    sidx = (int'(size) > NLANES) ? NLANES : int'(size);
    sbit = gath[sidx*8-1] & ~op_q[2];
    for (int b = 0; b < NLANES; b++) begin
      rdata_d[b*8 +: 8] = (b < sidx) ? gath[b*8 +: 8] : {8{sbit}};
    end
    if (!access_ok) rdata_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      op_q    <= 3'd0;
      off_q   <= '0;
      row_q   <= '0;
      wdata_q <= '0;
      wcnt_q  <= 3'd0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            op_q    <= mem_op_i;
            off_q   <= addr_i[OFF_W-1:0];
            row_q   <= addr_i[OFF_W +: DEPTH_LOG2];
            wdata_q <= wdata_i;
            busy_q  <= 1'b1;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          wcnt_q  <= 3'd0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wcnt_q <= wcnt_q + 3'd1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          fault_q <= 1'b0;
          if (upd_rdata) rdata_q <= rdata_d;
        end
        default: state_q <= S_IDLE;
      endcase
      if (go_done) begin
        state_q <= S_DONE;
        ready_q <= 1'b1;
        busy_q  <= 1'b0;
        fault_q <= legal && mis;
      end
    end
  end

  // Bank data is only available in DONE, so the fresh load value bypasses the hold register.
  assign rdata_o = ((state_q == S_DONE) && upd_rdata) ? rdata_d : rdata_q;
  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign fault_o = fault_q;

endmodule

// File: tb/tb_dmem_banked_ctrl.sv
// tb_dmem_banked_ctrl: directed scoreboard bench for dmem_banked_ctrl.
// Three instances: 32-bit/no wait, 32-bit/16 rows/3 waits, 64-bit/no wait.
// Expected responses are queued at issue and checked when ready_o pulses.
module tb_dmem_banked_ctrl;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req [3];
  logic        we  [3];
  logic [2:0]  op  [3];
  logic [31:0] ad  [3];
  logic [63:0] wd  [3];
  logic [31:0] rd0, rd1;
  logic [63:0] rd2;
  logic [63:0] rd  [3];
  logic        rdy [3];
  logic        bsy [3];
  logic        flt [3];

  assign rd[0] = {32'h0, rd0};
  assign rd[1] = {32'h0, rd1};
  assign rd[2] = rd2;

  dmem_banked_ctrl #(.DATA_W(32), .DEPTH_LOG2(14), .WAIT_CYCLES(0)) u0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .mem_op_i(op[0]),
    .addr_i(ad[0]), .wdata_i(wd[0][31:0]), .rdata_o(rd0), .ready_o(rdy[0]),
    .busy_o(bsy[0]), .fault_o(flt[0]));

  dmem_banked_ctrl #(.DATA_W(32), .DEPTH_LOG2(4), .WAIT_CYCLES(3)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .mem_op_i(op[1]),
    .addr_i(ad[1]), .wdata_i(wd[1][31:0]), .rdata_o(rd1), .ready_o(rdy[1]),
    .busy_o(bsy[1]), .fault_o(flt[1]));

  dmem_banked_ctrl #(.DATA_W(64), .DEPTH_LOG2(14), .WAIT_CYCLES(0)) u2 (
    .clk_i(clk), .rst_i(rst), .req_i(req[2]), .we_i(we[2]), .mem_op_i(op[2]),
    .addr_i(ad[2]), .wdata_i(wd[2]), .rdata_o(rd2), .ready_o(rdy[2]),
    .busy_o(bsy[2]), .fault_o(flt[2]));

  typedef struct {
    logic [63:0] rd;
    logic        f;
    int          cyc;
  } ent_t;

  ent_t        sbq [3][$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] last_rd [3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wt(int u);
    return (u == 1) ? 3 : 0;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (rdy[u] === 1'b1) begin
        if (sbq[u].size() == 0) begin
          chk($sformatf("u%0d_unexpected_ready", u), 64'd1, 64'd0);
        end else begin
          ent_t e;
          e = sbq[u].pop_front();
          chk($sformatf("u%0d_rdata", u), rd[u], e.rd);
          chk($sformatf("u%0d_fault", u), {63'd0, flt[u]}, {63'd0, e.f});
          chk($sformatf("u%0d_latency_cycle", u), 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic issue(int u, logic w, logic [2:0] o, logic [31:0] a, logic [63:0] d,
                       logic [63:0] er, logic ef);
    int n;
    @(posedge clk); #1;
    req[u] = 1'b1; we[u] = w; op[u] = o; ad[u] = a; wd[u] = d;
    sbq[u].push_back('{er, ef, cyc + 2 + wt(u)});
    @(posedge clk); #1;
    req[u] = 1'b0;
    n = 0;
    while (rdy[u] !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 30) chk($sformatf("u%0d_ready_timeout", u), 64'd0, 64'd1);
  endtask

  task automatic ld(int u, logic [2:0] o, logic [31:0] a, logic [63:0] e, logic f);
    issue(u, 1'b0, o, a, 64'h0, e, f);
    last_rd[u] = e;
  endtask

  // z: the store is rejected (fault or illegal op), so rdata reports zero.
  task automatic st(int u, logic [2:0] o, logic [31:0] a, logic [63:0] d, logic z, logic f);
    logic [63:0] er;
    er = z ? 64'h0 : last_rd[u];
    issue(u, 1'b1, o, a, d, er, f);
    last_rd[u] = er;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      req[u] = 1'b0; we[u] = 1'b0; op[u] = 3'd0; ad[u] = 32'h0; wd[u] = 64'h0;
      last_rd[u] = 64'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d_reset_rdata", u), rd[u], 64'h0);
      chk($sformatf("u%0d_reset_ready", u), {63'd0, rdy[u]}, 64'd0);
      chk($sformatf("u%0d_reset_busy", u), {63'd0, bsy[u]}, 64'd0);
      chk($sformatf("u%0d_reset_fault", u), {63'd0, flt[u]}, 64'd0);
    end
    rst = 1'b0;

    // Aligned word and sub-word loads.
    st(0, 3'd2, 32'h104, 64'h00C0FFEE, 1'b0, 1'b0);
    st(0, 3'd2, 32'h100, 64'hDEADBEEF, 1'b0, 1'b0);
    ld(0, 3'd2, 32'h100, 64'hDEADBEEF, 1'b0);
    ld(0, 3'd4, 32'h103, 64'h000000DE, 1'b0);
    ld(0, 3'd0, 32'h103, 64'hFFFFFFDE, 1'b0);
    ld(0, 3'd5, 32'h102, 64'h0000DEAD, 1'b0);
    ld(0, 3'd1, 32'h100, 64'hFFFFBEEF, 1'b0);

    // Misaligned word straddling rows 0x7F/0x80.
    st(0, 3'd2, 32'h1FC, 64'hA0A1A2A3, 1'b0, 1'b0);
    st(0, 3'd2, 32'h200, 64'hB0B1B2B3, 1'b0, 1'b0);
    st(0, 3'd2, 32'h1FD, 64'h11223344, TRAP, TRAP);
    ld(0, 3'd2, 32'h1FD, TRAP ? 64'h0 : 64'h11223344, TRAP);
    ld(0, 3'd4, 32'h200, TRAP ? 64'hB3 : 64'h11, 1'b0);
    ld(0, 3'd2, 32'h1FC, TRAP ? 64'hA0A1A2A3 : 64'h223344A3, 1'b0);

    // Misaligned half and word around 0x100.
    st(0, 3'd1, 32'h101, 64'h7777, TRAP, TRAP);
    ld(0, 3'd2, 32'h100, TRAP ? 64'hDEADBEEF : 64'hDE7777EF, 1'b0);
    ld(0, 3'd2, 32'h102, TRAP ? 64'h0 : 64'hFFEEDE77, TRAP);
    ld(0, 3'd2, 32'h104, 64'h00C0FFEE, 1'b0);

    // Illegal ops: op 7 and D on a 32-bit path.
    ld(0, 3'd7, 32'h100, 64'h0, 1'b0);
    st(0, 3'd7, 32'h100, 64'h12345678, 1'b1, 1'b0);
    ld(0, 3'd3, 32'h100, 64'h0, 1'b0);
    ld(0, 3'd2, 32'h100, TRAP ? 64'hDEADBEEF : 64'hDE7777EF, 1'b0);

    // Reset one cycle after a load request: no ready, everything low.
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; op[0] = 3'd2; ad[0] = 32'h104;
    @(posedge clk); #1;
    req[0] = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_rdata", rd[0], 64'h0);
    chk("rst_mid_ready", {63'd0, rdy[0]}, 64'd0);
    chk("rst_mid_busy", {63'd0, bsy[0]}, 64'd0);
    chk("rst_mid_fault", {63'd0, flt[0]}, 64'd0);
    rst = 1'b0;
    for (int u = 0; u < 3; u++) last_rd[u] = 64'h0;
    ld(0, 3'd2, 32'h104, 64'h00C0FFEE, 1'b0);

    // Row wrap on a 16-row instance with three wait states.
    st(1, 3'd2, 32'h00, 64'h01020304, 1'b0, 1'b0);
    st(1, 3'd2, 32'h3C, 64'h05060708, 1'b0, 1'b0);
    st(1, 3'd2, 32'h3F, 64'hAABBCCDD, TRAP, TRAP);
    ld(1, 3'd4, 32'h00, TRAP ? 64'h04 : 64'hCC, 1'b0);
    ld(1, 3'd4, 32'h3F, TRAP ? 64'h05 : 64'hDD, 1'b0);

    // req held high: accepted every 6 cycles, busy 4 cycles per access.
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; op[1] = 3'd4; ad[1] = 32'h01;
    for (int i = 0; i < 3; i++) sbq[1].push_back('{TRAP ? 64'h03 : 64'hBB, 1'b0, cyc + 5 + 6*i});
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bsy[1] === 1'b1) n++;
      if (i == 15) req[1] = 1'b0;
      @(posedge clk); #1;
    end
    chk("u1_busy_cycles", 64'(n), 64'd12);
    last_rd[1] = TRAP ? 64'h03 : 64'hBB;

    // A store requested while busy must be dropped.
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; op[1] = 3'd4; ad[1] = 32'h02;
    sbq[1].push_back('{TRAP ? 64'h02 : 64'hAA, 1'b0, cyc + 5});
    @(posedge clk); #1;
    we[1] = 1'b1; op[1] = 3'd0; wd[1] = 64'h55;
    repeat (3) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    req[1] = 1'b0; we[1] = 1'b0;
    last_rd[1] = TRAP ? 64'h02 : 64'hAA;
    ld(1, 3'd4, 32'h02, TRAP ? 64'h02 : 64'hAA, 1'b0);

    // 64-bit round trip and 32-bit extensions.
    st(2, 3'd3, 32'h8, 64'h0123456789ABCDEF, 1'b0, 1'b0);
    ld(2, 3'd3, 32'h8, 64'h0123456789ABCDEF, 1'b0);
    ld(2, 3'd2, 32'h8, 64'hFFFFFFFF89ABCDEF, 1'b0);
    ld(2, 3'd6, 32'hC, 64'h0000000001234567, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) chk($sformatf("u%0d_scoreboard_empty", u), 64'(sbq[u].size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
